// File: rtl/uart_ctrl_pkg.sv
// Shared UART control definitions: arbiter state encoding, transfer timeout
// default and 100 MHz baud divisors.
`timescale 1ns/100ps
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LAUNCH   = 2'd1,
    ST_WAIT_END = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam int unsigned TO_CYCLES_DEF = 100000;

  // clk cycles per bit at 100 MHz
  localparam int unsigned BAUD_DIV_9600   = 10417;
  localparam int unsigned BAUD_DIV_19200  = 5208;
  localparam int unsigned BAUD_DIV_57600  = 1736;
  localparam int unsigned BAUD_DIV_115200 = 868;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority scan: picks the first requester at or after ptr+1
// (mod N_REQ) and returns it one-hot and as a binary index.
`timescale 1ns/100ps
module rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] sel,
  output logic [IW-1:0]    idx
);
  localparam int unsigned SW = IW + 1;

  logic [IW-1:0]    start;
  logic [IW-1:0]    off;
  logic [N_REQ-1:0] rot;
  logic [SW-1:0]    sum;
  logic             hit;

  // Rotate so the top-priority requester sits at bit 0, find the lowest set
  // bit, then rotate the offset back into an absolute index.
  always_comb begin
    start = (ptr == IW'(N_REQ - 1)) ? '0 : ptr + IW'(1);
    rot   = N_REQ'({req, req} >> start);
    off   = '0;
    hit   = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        off = IW'(j);
        hit = 1'b1;
      end
    end
    sum = SW'(start) + SW'(off);
    idx = (sum >= SW'(N_REQ)) ? IW'(sum - SW'(N_REQ)) : IW'(sum);
    sel = hit ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ requesters: round-robin grant,
// byte hand-off, completion tracking via the transmitter busy flag, timeout.
`timescale 1ns/100ps
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic               err,
  output logic               busy,
  output logic               tx_ready,
  output logic [7:0]         tx_byte,
  input  logic               tx_status
);
  localparam int unsigned   IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned   CW       = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYCLES - 1);

  state_e           state;
  logic             st_q1;
  logic             st_s;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    own_idx;
  logic [IW-1:0]    arb_idx;
  logic [N_REQ-1:0] arb_sel;
  logic [CW-1:0]    cnt;
  logic             cnt_last;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req (req),
    .ptr (ptr),
    .sel (arb_sel),
    .idx (arb_idx)
  );

  assign cnt_last = (cnt == CNT_LAST);

  // tx_status comes from the baud-clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q1 <= 1'b0;
      st_s  <= 1'b0;
    end else begin
      st_q1 <= tx_status;
      st_s  <= st_q1;
    end
  end

  // Transfer FSM; the phase counter saturates at CNT_LAST, which ends the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= IW'(N_REQ - 1);
      own_idx  <= '0;
      cnt      <= '0;
      grant    <= '0;
      ack      <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      tx_ready <= 1'b0;
      tx_byte  <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant    <= arb_sel;
            own_idx  <= arb_idx;
            tx_byte  <= req_data[8*arb_idx +: 8];
            tx_ready <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (st_s) begin
            tx_ready <= 1'b0;
            cnt      <= '0;
            state    <= ST_WAIT_END;
          end else if (cnt_last) begin
            tx_ready <= 1'b0;
            ack      <= grant;
            err      <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WAIT_END: begin
          if (!st_s) begin
            ack   <= grant;
            state <= ST_DONE;
          end else if (cnt_last) begin
            ack   <= grant;
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          grant <= '0;
          ack   <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
          ptr   <= own_idx;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
